// File: rtl/execute_to_memory_stage_pkg.sv
// Shared encodings for the execute stage: ALU operations, R-type funct codes,
// ALUOp classes and forwarding-mux selects.
package execute_to_memory_stage_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_IMM    = 2'b11;

  localparam logic [1:0] FWD_REGFILE  = 2'b00;
  localparam logic [1:0] FWD_WB       = 2'b01;
  localparam logic [1:0] FWD_MEM      = 2'b10;
  localparam logic [1:0] FWD_REGFILE2 = 2'b11;

endpackage

// File: rtl/execute_to_memory_stage_alu.sv
// ALU control decode (ALUOp class + funct) feeding a DATA_W-bit ALU with a
// combinational zero flag.
module alu_control_and_alu
  import execute_to_memory_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              alu_op1_i,
  input  logic              alu_op0_i,
  input  logic [5:0]        funct_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] y_o,
  output logic              zero_o
);

  alu_op_e            op;
  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;

  always_comb begin
    op = ALU_ADD;
    case ({alu_op1_i, alu_op0_i})
      ALUOP_BRANCH: op = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct_i)
          FUNCT_SUB: op = ALU_SUB;
          FUNCT_AND: op = ALU_AND;
          FUNCT_OR:  op = ALU_OR;
          FUNCT_SLT: op = ALU_SLT;
          default:   op = ALU_ADD;
        endcase
      end
      default: op = ALU_ADD;
    endcase
  end

  assign a_s = a_i;
  assign b_s = b_i;

  // Arithmetic wraps modulo 2^DATA_W; overflow never traps.
  always_comb begin
    y_o = a_i + b_i;
    case (op)
      ALU_SUB: y_o = a_i - b_i;
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_SLT: y_o = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
      default: y_o = a_i + b_i;
    endcase
  end

  assign zero_o = (y_o == '0);

endmodule

// File: rtl/execute_to_memory_stage.sv
// EX stage of the 5-stage MIPS pipeline: operand forwarding, ALU, branch-target
// adder and the EX/MEM pipeline register with stall (hold) and flush (bubble).
module execute_to_memory_stage
  import execute_to_memory_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegDstIn,
  input  logic              ALUSrcIn,
  input  logic              MemtoRegIn,
  input  logic              RegWriteIn,
  input  logic              MemReadIn,
  input  logic              MemWriteIn,
  input  logic              BranchIn,
  input  logic              ALUOp1In,
  input  logic              ALUOp0In,
  input  logic [DATA_W-1:0] npc,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  input  logic [DATA_W-1:0] s_extend,
  input  logic [REG_W-1:0]  instr_2016,
  input  logic [REG_W-1:0]  instr_1511,
  input  logic [1:0]        fwd_a_sel,
  input  logic [1:0]        fwd_b_sel,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic              stall,
  input  logic              flush,
  output logic              MemtoRegOut,
  output logic              RegWriteOut,
  output logic              MemReadOut,
  output logic              MemWriteOut,
  output logic              BranchOut,
  output logic [DATA_W-1:0] branch_target,
  output logic              zero,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] store_data,
  output logic [REG_W-1:0]  write_reg
);

  function automatic logic [DATA_W-1:0] fwd_mux(input logic [1:0]        sel,
                                                input logic [DATA_W-1:0] rf,
                                                input logic [DATA_W-1:0] wb,
                                                input logic [DATA_W-1:0] mem);
    case (sel)
      FWD_WB:  return wb;
      FWD_MEM: return mem;
      default: return rf;
    endcase
  endfunction

  logic [DATA_W-1:0] op_a_d, fwd_b_d, op_b_d, alu_d, bt_d;
  logic              zero_d;
  logic [REG_W-1:0]  wr_d;

  logic              m2r_q, rw_q, mr_q, mw_q, br_q, zero_q;
  logic [DATA_W-1:0] bt_q, alu_q, sd_q;
  logic [REG_W-1:0]  wr_q;

  assign op_a_d  = fwd_mux(fwd_a_sel, rdata1, wb_data, mem_alu_result);
  assign fwd_b_d = fwd_mux(fwd_b_sel, rdata2, wb_data, mem_alu_result);
  assign op_b_d  = ALUSrcIn ? s_extend : fwd_b_d;
  assign bt_d    = npc + (s_extend << 2);
  assign wr_d    = RegDstIn ? instr_1511 : instr_2016;

  alu_control_and_alu #(.DATA_W(DATA_W)) u_alu (
    .alu_op1_i (ALUOp1In),
    .alu_op0_i (ALUOp0In),
    .funct_i   (s_extend[5:0]),
    .a_i       (op_a_d),
    .b_i       (op_b_d),
    .y_o       (alu_d),
    .zero_o    (zero_d)
  );

  // EX/MEM register: reset > flush > stall > load; a bubble clears only control.
  always_ff @(posedge clk) begin
    if (reset) begin
      m2r_q  <= 1'b0;
      rw_q   <= 1'b0;
      mr_q   <= 1'b0;
      mw_q   <= 1'b0;
      br_q   <= 1'b0;
      bt_q   <= '0;
      zero_q <= 1'b0;
      alu_q  <= '0;
      sd_q   <= '0;
      wr_q   <= '0;
    end else if (flush || !stall) begin
      m2r_q  <= flush ? 1'b0 : MemtoRegIn;
      rw_q   <= flush ? 1'b0 : RegWriteIn;
      mr_q   <= flush ? 1'b0 : MemReadIn;
      mw_q   <= flush ? 1'b0 : MemWriteIn;
      br_q   <= flush ? 1'b0 : BranchIn;
      bt_q   <= bt_d;
      zero_q <= zero_d;
      alu_q  <= alu_d;
      sd_q   <= fwd_b_d;
      wr_q   <= wr_d;
    end
  end

  assign MemtoRegOut   = m2r_q;
  assign RegWriteOut   = rw_q;
  assign MemReadOut    = mr_q;
  assign MemWriteOut   = mw_q;
  assign BranchOut     = br_q;
  assign branch_target = bt_q;
  assign zero          = zero_q;
  assign alu_result    = alu_q;
  assign store_data    = sd_q;
  assign write_reg     = wr_q;

endmodule
